proc_ctrl_fsm: RTL and testbench
================================

Name: proc_ctrl_fsm

Overview:
- Control unit for the ProjectB processor.
- Sequences the PC counter and latches instructions from instruction memory into its internal IR.
- Decodes each instruction and drives the data memory, register file and ALU control lines, one instruction at a time.
- Sits between the PC counter and instruction memory on one side and the datapath (data RAM, register file, ALU) on the other.

Parameters:
- INSTR_W, 16, instruction width. Must equal 4+D_ADDR_W+R_ADDR_W and 4+3*R_ADDR_W.
- D_ADDR_W, 8, data memory address width.
- R_ADDR_W, 4, register file address width.

Ports:
- clk  input  1  system clock, rising edge active.
- clear_n  input  1  asynchronous, active-low reset.
- instr  input  INSTR_W  instruction memory read data. Combinational read of the current PC address.
- pc_clr  output  1  synchronous clear to the PC counter.
- pc_up  output  1  increment request to the PC counter.
- ir  output  INSTR_W  current IR contents, for display and debug.
- d_addr  output  D_ADDR_W  data memory address.
- d_wr  output  1  data memory write enable.
- rf_s  output  1  RF write-data select: 1 = data memory, 0 = ALU.
- rf_w_addr  output  R_ADDR_W  RF write address.
- rf_w_en  output  1  RF write enable.
- rf_ra_addr  output  R_ADDR_W  RF read port A address.
- rf_rb_addr  output  R_ADDR_W  RF read port B address.
- alu_s  output  2  ALU function: 00 = pass A, 01 = A+B, 10 = A-B.
- state  output  4  current state encoding.
- halted  output  1  high while in Halt.

Behaviour:
- Reset: clear_n is asynchronous and active-low. Reset forces state = Init and ir = 0.
- While clear_n = 0, only pc_clr = 1. All other outputs are 0 and halted = 0.
- State encoding: Init=0, Fetch=1, Decode=2, Noop=3, LoadA=4, LoadB=5, Store=6, Add=7, Sub=8, Halt=9. States 10-15 are illegal and go to Init on the next edge.
- Outputs are combinational from state and ir. The only registers are the state and the IR. Every output not listed for a state is 0 in that state.
- Init: pc_clr=1. Next state is Fetch. Init lasts exactly 1 cycle after clear_n deasserts.
- Fetch: pc_up=1. IR loads instr on the same edge that the PC increments, so IR holds mem[PC] and PC becomes PC+1. Next state is Decode.
- Decode: no outputs. Next state is chosen by ir[15:12]:
  - 0000 goes to Noop.
  - 0001 goes to Store.
  - 0010 goes to LoadA.
  - 0011 goes to Add.
  - 0100 goes to Sub.
  - 0101 goes to Halt.
  - 0110-1111 are undefined and go to Noop.
- Noop: no outputs. Next state is Fetch.
- Store, format [op|Ra|d]: rf_ra_addr=ir[11:8], d_addr=ir[7:0], alu_s=00, d_wr=1. Next state is Fetch.
- LoadA, format [op|d|Rd]: d_addr=ir[11:4], rf_s=1, rf_w_addr=ir[3:0], with rf_w_en=0 to allow the RAM read. Next state is LoadB.
- LoadB: same address and select lines as LoadA, with rf_w_en=1. Next state is Fetch.
- Add, format [op|Ra|Rb|Rd]: rf_ra_addr=ir[11:8], rf_rb_addr=ir[7:4], alu_s=01, rf_s=0, rf_w_addr=ir[3:0], rf_w_en=1. Next state is Fetch.
- Sub: same as Add but alu_s=10. Next state is Fetch.
- Halt: halted=1. No pc_up, no writes. Only clear_n exits Halt.
- Cycle counts per instruction: Noop, Store, Add and Sub take 3 cycles (Fetch, Decode, Exec). Load takes 4 cycles. PC advances exactly once per instruction.
- IR is written only in Fetch. IR is held in all other states, including Halt.
- PC wrap-around from 255 to 0 is the counter's responsibility. The controller simply keeps fetching.
- Reset mid-instruction: the next clock-independent response is state=Init and pc_clr=1. No write strobe may be high while clear_n = 0.

Test Plan:
- Reset, then release clear_n with instr=16'h0000. Require: Init lasts 1 cycle with pc_clr=1, then Fetch with pc_up=1, then Decode, then Noop, then Fetch. State sequence is 0,1,2,3,1.
- instr=16'h2A53 (LOAD D[0xA5] to R3). Require: LoadA shows d_addr=A5, rf_s=1, rf_w_addr=3, rf_w_en=0. LoadB shows the same lines with rf_w_en=1. Then Fetch. Total 4 cycles.
- instr=16'h1607 (STORE R6 to D[0x07]). Require: exactly one cycle with d_wr=1, rf_ra_addr=6, d_addr=07, alu_s=00, and rf_w_en=0 throughout.
- instr=16'h3125 then 16'h4125. Require: ADD cycle shows rf_ra_addr=1, rf_rb_addr=2, rf_w_addr=5, alu_s=01, rf_w_en=1. SUB cycle is identical except alu_s=10. Exactly 2 pc_up pulses in total.
- instr=16'h5000. Require: after Decode, state=9 and halted=1 for 20+ cycles, with pc_up, d_wr and rf_w_en all 0. Changing instr must not alter ir.
- instr=16'hF123 (undefined opcode) executes as Noop. Separately, pulse clear_n low during LoadA. Require: state=0, pc_clr=1 and rf_w_en=0 immediately, then a normal Init to Fetch restart.

Source files
------------

// File: rtl/proc_ctrl_fsm.sv
// Control unit for the ProjectB processor: sequences the PC, latches instructions
// into the IR and drives data memory, register file and ALU control lines.
module proc_ctrl_fsm #(
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned D_ADDR_W = 8,
    parameter int unsigned R_ADDR_W = 4
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic [INSTR_W-1:0]  instr,
    output logic                pc_clr,
    output logic                pc_up,
    output logic [INSTR_W-1:0]  ir,
    output logic [D_ADDR_W-1:0] d_addr,
    output logic                d_wr,
    output logic                rf_s,
    output logic [R_ADDR_W-1:0] rf_w_addr,
    output logic                rf_w_en,
    output logic [R_ADDR_W-1:0] rf_ra_addr,
    output logic [R_ADDR_W-1:0] rf_rb_addr,
    output logic [1:0]          alu_s,
    output logic [3:0]          state,
    output logic                halted
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned OP_LO = INSTR_W - OP_W;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOADA  = 4'd4,
        S_LOADB  = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_e;

    localparam logic [OP_W-1:0] OP_NOOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_STORE = 4'h1;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD   = 4'h3;
    localparam logic [OP_W-1:0] OP_SUB   = 4'h4;
    localparam logic [OP_W-1:0] OP_HALT  = 4'h5;

    state_e          state_q;
    logic [OP_W-1:0] opcode;

    // Instruction fields: [op|Ra|d], [op|d|Rd], [op|Ra|Rb|Rd]
    logic [R_ADDR_W-1:0] fld_ra;
    logic [R_ADDR_W-1:0] fld_rb;
    logic [R_ADDR_W-1:0] fld_rd;
    logic [D_ADDR_W-1:0] fld_d_lo;
    logic [D_ADDR_W-1:0] fld_d_hi;

    assign opcode   = ir[INSTR_W-1 -: OP_W];
    assign fld_ra   = ir[OP_LO-1 -: R_ADDR_W];
    assign fld_rb   = ir[OP_LO-1-R_ADDR_W -: R_ADDR_W];
    assign fld_rd   = ir[R_ADDR_W-1:0];
    assign fld_d_lo = ir[D_ADDR_W-1:0];
    assign fld_d_hi = ir[OP_LO-1 -: D_ADDR_W];

    // State and IR registers; IR only loads in Fetch, alongside the PC increment
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_INIT;
            ir      <= '0;
        end else begin
            case (state_q)
                S_INIT:   state_q <= S_FETCH;
                S_FETCH: begin
                    state_q <= S_DECODE;
                    ir      <= instr;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_NOOP:  state_q <= S_NOOP;
                        OP_STORE: state_q <= S_STORE;
                        OP_LOAD:  state_q <= S_LOADA;
                        OP_ADD:   state_q <= S_ADD;
                        OP_SUB:   state_q <= S_SUB;
                        OP_HALT:  state_q <= S_HALT;
                        default:  state_q <= S_NOOP;
                    endcase
                end
                S_NOOP:   state_q <= S_FETCH;
                S_LOADA:  state_q <= S_LOADB;
                S_LOADB:  state_q <= S_FETCH;
                S_STORE:  state_q <= S_FETCH;
                S_ADD:    state_q <= S_FETCH;
                S_SUB:    state_q <= S_FETCH;
                S_HALT:   state_q <= S_HALT;
                default:  state_q <= S_INIT;
            endcase
        end
    end

    // Moore decode: outputs depend only on the state and IR registers, so reset
    // takes effect on every output without waiting for a clock
    always_comb begin
        pc_clr     = 1'b0;
        pc_up      = 1'b0;
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_addr  = '0;
        rf_w_en    = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_s      = 2'b00;
        halted     = 1'b0;
        case (state_q)
            S_INIT:  pc_clr = 1'b1;
            S_FETCH: pc_up  = 1'b1;
            S_STORE: begin
                rf_ra_addr = fld_ra;
                d_addr     = fld_d_lo;
                alu_s      = 2'b00;
                d_wr       = 1'b1;
            end
            S_LOADA, S_LOADB: begin
                d_addr    = fld_d_hi;
                rf_s      = 1'b1;
                rf_w_addr = fld_rd;
                rf_w_en   = (state_q == S_LOADB);
            end
            S_ADD, S_SUB: begin
                rf_ra_addr = fld_ra;
                rf_rb_addr = fld_rb;
                alu_s      = (state_q == S_SUB) ? 2'b10 : 2'b01;
                rf_s       = 1'b0;
                rf_w_addr  = fld_rd;
                rf_w_en    = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign state = 4'(state_q);

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Directed bench for proc_ctrl_fsm: walks NOOP, LOAD, STORE, ADD, SUB, undefined,
// HALT and a mid-instruction reset, checking outputs on the falling edge.
module tb_proc_ctrl_fsm;

    logic        clk;
    logic        clear_n;
    logic [15:0] instr;
    logic        pc_clr;
    logic        pc_up;
    logic [15:0] ir;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic        rf_s;
    logic [3:0]  rf_w_addr;
    logic        rf_w_en;
    logic [3:0]  rf_ra_addr;
    logic [3:0]  rf_rb_addr;
    logic [1:0]  alu_s;
    logic [3:0]  state;
    logic        halted;

    int n_vec;
    int n_err;
    int pc_pulses;
    int pc_mark;

    proc_ctrl_fsm dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .instr      (instr),
        .pc_clr     (pc_clr),
        .pc_up      (pc_up),
        .ir         (ir),
        .d_addr     (d_addr),
        .d_wr       (d_wr),
        .rf_s       (rf_s),
        .rf_w_addr  (rf_w_addr),
        .rf_w_en    (rf_w_en),
        .rf_ra_addr (rf_ra_addr),
        .rf_rb_addr (rf_rb_addr),
        .alu_s      (alu_s),
        .state      (state),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the PC counter: counts increment requests taken on an edge
    always @(posedge clk) begin
        if (clear_n && pc_up) pc_pulses <= pc_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Checks every output that is quiet outside the listed strobes
    task automatic chk_idle(input string tag, input logic [3:0] exp_state);
        chk({tag, ".state"},   32'(state), 32'(exp_state));
        chk({tag, ".d_wr"},    32'(d_wr), 32'd0);
        chk({tag, ".rf_w_en"}, 32'(rf_w_en), 32'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        pc_pulses = 0;
        clear_n   = 1'b0;
        instr     = 16'h0000;

        // Reset state
        #12;
        chk("rst.state",  32'(state), 32'd0);
        chk("rst.pc_clr", 32'(pc_clr), 32'd1);
        chk("rst.pc_up",  32'(pc_up), 32'd0);
        chk("rst.ir",     32'(ir), 32'h0);
        chk("rst.halted", 32'(halted), 32'd0);
        chk("rst.d_wr",   32'(d_wr), 32'd0);

        // NOOP: 0,1,2,3,1
        step();
        clear_n = 1'b1;
        chk("init.state", 32'(state), 32'd0);
        chk("init.pc_clr", 32'(pc_clr), 32'd1);
        step();
        chk("fetch0.state", 32'(state), 32'd1);
        chk("fetch0.pc_up", 32'(pc_up), 32'd1);
        chk("fetch0.pc_clr", 32'(pc_clr), 32'd0);
        step();
        chk_idle("dec0", 4'd2);
        chk("dec0.pc_up", 32'(pc_up), 32'd0);
        step();
        chk_idle("noop0", 4'd3);
        step();
        chk("fetch1.state", 32'(state), 32'd1);

        // LOAD D[A5] -> R3
        instr = 16'h2A53;
        step();
        chk_idle("dec1", 4'd2);
        chk("dec1.ir", 32'(ir), 32'h2A53);
        step();
        chk("loada.state", 32'(state), 32'd4);
        chk("loada.d_addr", 32'(d_addr), 32'hA5);
        chk("loada.rf_s", 32'(rf_s), 32'd1);
        chk("loada.rf_w_addr", 32'(rf_w_addr), 32'd3);
        chk("loada.rf_w_en", 32'(rf_w_en), 32'd0);
        step();
        chk("loadb.state", 32'(state), 32'd5);
        chk("loadb.d_addr", 32'(d_addr), 32'hA5);
        chk("loadb.rf_s", 32'(rf_s), 32'd1);
        chk("loadb.rf_w_addr", 32'(rf_w_addr), 32'd3);
        chk("loadb.rf_w_en", 32'(rf_w_en), 32'd1);
        step();
        chk_idle("fetch2", 4'd1);

        // STORE R6 -> D[07]
        instr = 16'h1607;
        step();
        chk_idle("dec2", 4'd2);
        step();
        chk("store.state", 32'(state), 32'd6);
        chk("store.d_wr", 32'(d_wr), 32'd1);
        chk("store.rf_ra_addr", 32'(rf_ra_addr), 32'd6);
        chk("store.d_addr", 32'(d_addr), 32'h07);
        chk("store.alu_s", 32'(alu_s), 32'd0);
        chk("store.rf_w_en", 32'(rf_w_en), 32'd0);
        step();
        chk_idle("fetch3", 4'd1);

        // ADD then SUB, R1,R2 -> R5
        pc_mark = pc_pulses;
        instr = 16'h3125;
        step();
        chk_idle("dec3", 4'd2);
        step();
        chk("add.state", 32'(state), 32'd7);
        chk("add.rf_ra_addr", 32'(rf_ra_addr), 32'd1);
        chk("add.rf_rb_addr", 32'(rf_rb_addr), 32'd2);
        chk("add.rf_w_addr", 32'(rf_w_addr), 32'd5);
        chk("add.alu_s", 32'(alu_s), 32'd1);
        chk("add.rf_s", 32'(rf_s), 32'd0);
        chk("add.rf_w_en", 32'(rf_w_en), 32'd1);
        chk("add.d_wr", 32'(d_wr), 32'd0);
        step();
        chk_idle("fetch4", 4'd1);
        instr = 16'h4125;
        step();
        chk_idle("dec4", 4'd2);
        step();
        chk("sub.state", 32'(state), 32'd8);
        chk("sub.rf_ra_addr", 32'(rf_ra_addr), 32'd1);
        chk("sub.rf_rb_addr", 32'(rf_rb_addr), 32'd2);
        chk("sub.rf_w_addr", 32'(rf_w_addr), 32'd5);
        chk("sub.alu_s", 32'(alu_s), 32'd2);
        chk("sub.rf_w_en", 32'(rf_w_en), 32'd1);
        step();
        chk_idle("fetch5", 4'd1);
        chk("addsub.pc_pulses", 32'(pc_pulses - pc_mark), 32'd2);

        // Undefined opcode behaves as NOOP
        instr = 16'hF123;
        step();
        chk_idle("dec5", 4'd2);
        chk("dec5.ir", 32'(ir), 32'hF123);
        step();
        chk_idle("undef", 4'd3);
        step();
        chk_idle("fetch6", 4'd1);

        // HALT holds with IR frozen regardless of instr
        instr = 16'h5000;
        step();
        chk_idle("dec6", 4'd2);
        pc_mark = pc_pulses;
        for (int i = 0; i < 22; i++) begin
            step();
            instr = 16'($urandom);
            chk_idle("halt", 4'd9);
            chk("halt.halted", 32'(halted), 32'd1);
            chk("halt.pc_up", 32'(pc_up), 32'd0);
            chk("halt.ir", 32'(ir), 32'h5000);
        end
        chk("halt.pc_pulses", 32'(pc_pulses - pc_mark), 32'd0);

        // Reset out of Halt, then reset mid-LoadA
        clear_n = 1'b0;
        #1;
        chk("haltrst.state", 32'(state), 32'd0);
        chk("haltrst.halted", 32'(halted), 32'd0);
        step();
        clear_n = 1'b1;
        instr = 16'h2A53;
        step();
        chk("fetch7.state", 32'(state), 32'd1);
        step();
        chk_idle("dec7", 4'd2);
        step();
        chk("loada2.state", 32'(state), 32'd4);
        #2;
        clear_n = 1'b0;
        #1;
        chk("midrst.state", 32'(state), 32'd0);
        chk("midrst.pc_clr", 32'(pc_clr), 32'd1);
        chk("midrst.rf_w_en", 32'(rf_w_en), 32'd0);
        chk("midrst.d_wr", 32'(d_wr), 32'd0);
        chk("midrst.ir", 32'(ir), 32'h0);
        step();
        step();
        chk("midrst.hold", 32'(state), 32'd0);
        clear_n = 1'b1;
        chk("reinit.pc_clr", 32'(pc_clr), 32'd1);
        step();
        chk("refetch.state", 32'(state), 32'd1);
        chk("refetch.pc_up", 32'(pc_up), 32'd1);
        step();
        chk("redec.ir", 32'(ir), 32'h2A53);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
